// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// regfile_writeback_queue: in-order queue of ALU/load results feeding the register file write port.
// Optional youngest-match bypass lookup, built only when macro WB_BYPASS_EN is defined.
module regfile_writeback_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    alu_valid,
   input  logic [ADDR_WIDTH-1:0]   alu_rd,
   input  logic [DATA_WIDTH-1:0]   alu_data,
   output logic                    alu_ready,
   input  logic                    mem_valid,
   input  logic [ADDR_WIDTH-1:0]   mem_rd,
   input  logic [DATA_WIDTH-1:0]   mem_data,
   output logic                    mem_ready,
   output logic                    reg_write,
   output logic [ADDR_WIDTH-1:0]   rd,
   output logic [DATA_WIDTH-1:0]   write_data,
   input  logic [ADDR_WIDTH-1:0]   rs1,
   input  logic [ADDR_WIDTH-1:0]   rs2,
   output logic                    rs1_hit,
   output logic [DATA_WIDTH-1:0]   rs1_fwd,
   output logic                    rs2_hit,
   output logic [DATA_WIDTH-1:0]   rs2_fwd,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] q_rd   [DEPTH];
   logic [DATA_WIDTH-1:0] q_data [DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [PW-1:0]         alu_slot;
   logic [CW-1:0]         free;
   logic [CW-1:0]         pushes;
   logic                  pop;
   logic                  push_mem;
   logic                  push_alu;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign pop   = !empty;

   // The head is always popped this cycle, so its slot counts as free.
   assign free      = CW'(DEPTH) - count + CW'(pop);
   assign mem_ready = (free >= CW'(1));
   assign alu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid);

   // x0 results are acknowledged but dropped.
   assign push_mem = mem_valid && mem_ready && (mem_rd != '0);
   assign push_alu = alu_valid && alu_ready && (alu_rd != '0);
   assign pushes   = CW'(push_mem) + CW'(push_alu);
   assign alu_slot = tail + PW'(push_mem);

   assign reg_write  = pop;
   assign rd         = empty ? '0 : q_rd[head];
   assign write_data = empty ? '0 : q_data[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_rd[i]   <= '0;
            q_data[i] <= '0;
         end
      end else begin
         if (push_mem) begin
            q_rd[tail]   <= mem_rd;
            q_data[tail] <= mem_data;
         end
         if (push_alu) begin
            q_rd[alu_slot]   <= alu_rd;
            q_data[alu_slot] <= alu_data;
         end
         head  <= head + PW'(pop);
         tail  <= tail + PW'(push_mem) + PW'(push_alu);
         count <= count - CW'(pop) + pushes;
      end
   end

`ifdef WB_BYPASS_EN
   // Scan oldest to youngest so the youngest match is the last one written.
   always_comb begin
      rs1_hit = 1'b0;
      rs1_fwd = '0;
      rs2_hit = 1'b0;
      rs2_fwd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) begin
            if ((rs1 != '0) && (q_rd[head + PW'(i)] == rs1)) begin
               rs1_hit = 1'b1;
               rs1_fwd = q_data[head + PW'(i)];
            end
            if ((rs2 != '0) && (q_rd[head + PW'(i)] == rs2)) begin
               rs2_hit = 1'b1;
               rs2_fwd = q_data[head + PW'(i)];
            end
         end
      end
   end
`else
   logic unused_rs;
   assign unused_rs = ^{rs1, rs2};
   assign rs1_hit   = 1'b0;
   assign rs1_fwd   = '0;
   assign rs2_hit   = 1'b0;
   assign rs2_fwd   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// tb_regfile_writeback_queue: directed stimulus checked every negedge against a queue-level model.
module tb_regfile_writeback_queue;
   localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, mem_valid;
   logic [4:0]  alu_rd, mem_rd, rs1, rs2, rd;
   logic [31:0] alu_data, mem_data, write_data, rs1_fwd, rs2_fwd;
   logic        alu_ready, mem_ready, reg_write, rs1_hit, rs2_hit, full, empty;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0]  mq_rd [$];
   logic [31:0] mq_d  [$];

   regfile_writeback_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .reg_write(reg_write), .rd(rd), .write_data(write_data),
      .rs1(rs1), .rs2(rs2), .rs1_hit(rs1_hit), .rs1_fwd(rs1_fwd),
      .rs2_hit(rs2_hit), .rs2_fwd(rs2_fwd),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_free();
      return DEPTH - mq_rd.size() + ((mq_rd.size() != 0) ? 1 : 0);
   endfunction

   function automatic logic [32:0] model_lookup(input logic [4:0] rs);
      if (rs == 5'd0) return 33'd0;
      for (int i = mq_rd.size() - 1; i >= 0; i--)
         if (mq_rd[i] == rs) return {1'b1, mq_d[i]};
      return 33'd0;
   endfunction

   always @(negedge rst_n) begin
      mq_rd.delete();
      mq_d.delete();
   end

   // Model: one write per cycle from the front, then mem before alu at the back.
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         int  f;
         bit  m_acc, a_acc;
         f     = model_free();
         m_acc = mem_valid && (f >= 1);
         a_acc = alu_valid && ((f >= 2) || ((f >= 1) && !mem_valid));
         if (mq_rd.size() != 0) begin
            void'(mq_rd.pop_front());
            void'(mq_d.pop_front());
         end
         if (m_acc && mem_rd != 5'd0) begin mq_rd.push_back(mem_rd); mq_d.push_back(mem_data); end
         if (a_acc && alu_rd != 5'd0) begin mq_rd.push_back(alu_rd); mq_d.push_back(alu_data); end
      end
   end

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         chk("rst_reg_write", reg_write, 0);
         chk("rst_count", count, 0);
         chk("rst_wdata", write_data, 0);
         chk("rst_hits", {rs1_hit, rs2_hit}, 0);
      end else begin
         int f;
         logic [32:0] l1, l2;
         f  = model_free();
         l1 = BYP ? model_lookup(rs1) : 33'd0;
         l2 = BYP ? model_lookup(rs2) : 33'd0;
         chk("cmp_count", count, mq_rd.size());
         chk("cmp_empty", empty, mq_rd.size() == 0);
         chk("cmp_full", full, mq_rd.size() == DEPTH);
         chk("cmp_reg_write", reg_write, mq_rd.size() != 0);
         chk("cmp_rd", rd, (mq_rd.size() != 0) ? mq_rd[0] : 5'd0);
         chk("cmp_wdata", write_data, (mq_d.size() != 0) ? mq_d[0] : 32'd0);
         chk("cmp_mem_ready", mem_ready, f >= 1);
         chk("cmp_alu_ready", alu_ready, (f >= 2) || ((f >= 1) && !mem_valid));
         chk("cmp_rs1", {rs1_hit, rs1_fwd}, l1);
         chk("cmp_rs2", {rs2_hit, rs2_fwd}, l2);
      end
   end

   task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad);
      mem_valid = mv; mem_rd = mr; mem_data = md;
      alu_valid = av; alu_rd = ar; alu_data = ad;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      rs1 = '0; rs2 = '0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_count", count, 0);
      chk("reset_empty", empty, 1);
      chk("reset_full", full, 0);
      chk("reset_rd", rd, 0);

      // Single ALU push, written in the following cycle.
      drive(0, 0, 0, 1, 5'd5, 32'h1234);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t1_reg_write", reg_write, 1);
      chk("t1_rd", rd, 5);
      chk("t1_wdata", write_data, 32'h1234);
      step();
      chk("t1_empty", empty, 1);
      chk("t1_reg_write_off", reg_write, 0);

      // Both sources at once into an empty queue: mem first.
      drive(1, 5'd3, 32'hAAAA, 1, 5'd4, 32'hBBBB);
      #1;
      chk("t2_mem_ready", mem_ready, 1);
      chk("t2_alu_ready", alu_ready, 1);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t2_first_rd", rd, 3);
      chk("t2_first_data", write_data, 32'hAAAA);
      step();
      chk("t2_second_rd", rd, 4);
      chk("t2_second_data", write_data, 32'hBBBB);
      step();
      chk("t2_empty", empty, 1);

      // Fill with both sources every cycle; saturates at DEPTH.
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'((2 * i) % 31 + 1), 32'h100 + i, 1, 5'((2 * i + 1) % 31 + 1), 32'h200 + i);
         #1;
         chk("t3_occupancy", count <= 3'd4, 1);
         if (i >= 3) begin
            chk("t3_full_count", count, 4);
            chk("t3_mem_ready", mem_ready, 1);
            chk("t3_alu_ready", alu_ready, 0);
         end
         step();
      end
      drive(0, 0, 0, 0, 0, 0);
      repeat (5) step();
      chk("t3_drained", empty, 1);

      // x0 destination: acknowledged, not queued.
      drive(0, 0, 0, 1, 5'd0, 32'hFFFF);
      #1;
      chk("t4_alu_ready", alu_ready, 1);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t4_count", count, 0);
      chk("t4_reg_write", reg_write, 0);

      // Two pending writes to x7: the younger one forwards.
      rs1 = 5'd7; rs2 = 5'd0;
      drive(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t5_count", count, 2);
      chk("t5_rs1_hit", rs1_hit, BYP);
      chk("t5_rs1_fwd", rs1_fwd, BYP ? 32'h22 : 32'h0);
      chk("t5_rs2_hit", rs2_hit, 0);
      step();
      step();
      chk("t5_miss", rs1_hit, 0);
      rs1 = '0;

      // Asynchronous reset with three entries pending.
      drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
      step();
      drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t6_pending", count, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_reg_write", reg_write, 0);
      chk("t6_async_count", count, 0);
      chk("t6_async_empty", empty, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 0, 0, 1, 5'd9, 32'h99);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("t6_new_rd", rd, 9);
      chk("t6_new_data", write_data, 32'h99);
      chk("t6_new_count", count, 1);
      step();
      chk("t6_no_stale", empty, 1);

      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
